// File: rtl/fifo_ram_if.sv
// fifo_ram_if: stream bundle between fifo_ram and its surrounding FIFOs.
//   data_in_*  : show-ahead write FIFO (packed address + data [+ byte mask])
//   addr_in_*  : show-ahead read-address FIFO
//   data_out_* : downstream read-data FIFO
//   addr_err   : sticky out-of-range flag from the RAM
// Modports: master = RAM side, slave = FIFO/environment side.
// The word width grows by DW/8 mask bits when FIFO_RAM_WMASK_EN is defined.
interface fifo_ram_if #(
    parameter int DW = 16,
    parameter int AW = 14,
`ifdef FIFO_RAM_WMASK_EN
    parameter int WW = AW + DW + DW / 8
`else
    parameter int WW = AW + DW
`endif
);
    logic          data_in_ren;
    logic [WW-1:0] data_in_rd;
    logic          data_in_empty;
    logic          addr_in_ren;
    logic [AW-1:0] addr_in_rd;
    logic          addr_in_empty;
    logic          data_out_wen;
    logic [DW-1:0] data_out_wd;
    logic          data_out_full;
    logic          addr_err;

    modport master (
        output data_in_ren,
        input  data_in_rd,
        input  data_in_empty,
        output addr_in_ren,
        input  addr_in_rd,
        input  addr_in_empty,
        output data_out_wen,
        output data_out_wd,
        input  data_out_full,
        output addr_err
    );

    modport slave (
        input  data_in_ren,
        output data_in_rd,
        output data_in_empty,
        input  addr_in_ren,
        output addr_in_rd,
        output addr_in_empty,
        input  data_out_wen,
        input  data_out_wd,
        output data_out_full,
        input  addr_err
    );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: single-port frame RAM fed by show-ahead FIFOs.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - fifo_ram_if.master: write-word pop, read-address pop,
//            read-data push and sticky addr_err
// One memory access per cycle; reads go through a registered memory output
// and a 3-entry skid buffer so read data survives data_out_full.
// Optional feature: define FIFO_RAM_WMASK_EN for per-byte write enables
// carried in the top DW/8 bits of the write word.
module fifo_ram #(
    parameter int DW       = 16,
    parameter int AW       = 14,
    parameter int DEPTH    = 16384,
    parameter int ARB_MODE = 0
) (
    input logic clk,
    input logic rst_n,
    fifo_ram_if.master bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FIFO_RAM_WMASK_EN
    localparam int MW = DW / 8;
`endif

    logic [DW-1:0] mem [DEPTH];

    logic          run;
    logic          last;          // 1: read granted last, 0: write granted last
    logic          rd_pipe_valid;
    logic          rd_pipe_oor;
    logic [DW-1:0] rd_raw;
    logic [DW-1:0] skid [3];
    logic [1:0]    skid_wp;
    logic [1:0]    skid_rp;
    logic [1:0]    skid_cnt;
    logic          addr_err_q;

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_oor;
    logic          wr_oor;
    logic [2:0]    in_flight;
    logic          rd_req;
    logic          wr_req;
    logic          rd_gnt;
    logic          wr_gnt;
    logic          push;
    logic          pop;

    assign rd_addr = bus.addr_in_rd;
    assign wr_addr = bus.data_in_rd[AW+DW-1:DW];
    assign wr_data = bus.data_in_rd[DW-1:0];
    assign rd_oor  = 32'(rd_addr) >= DEPTH;
    assign wr_oor  = 32'(wr_addr) >= DEPTH;

    // Credit covers the word in the memory output register as well as the
    // skid, so every granted read is guaranteed a skid slot.
    assign in_flight = {1'b0, skid_cnt} + {2'b00, rd_pipe_valid};
    assign rd_req    = ~bus.addr_in_empty & (in_flight < 3'd3);
    assign wr_req    = ~bus.data_in_empty;

    // run holds grants off while in reset and for the first edge after it.
    always_comb begin
        rd_gnt = run & rd_req & ((ARB_MODE == 0) | ~wr_req | ~last);
        wr_gnt = run & wr_req & ~rd_gnt;
    end

    assign push = rd_pipe_valid;
    assign pop  = (skid_cnt != 2'd0) & ~bus.data_out_full;

    assign bus.addr_in_ren  = rd_gnt;
    assign bus.data_in_ren  = wr_gnt;
    assign bus.data_out_wen = pop;
    assign bus.data_out_wd  = skid[skid_rp];
    assign bus.addr_err     = addr_err_q;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Memory array and its output register carry no reset.
    always_ff @(posedge clk) begin
        if (wr_gnt && !wr_oor) begin
`ifdef FIFO_RAM_WMASK_EN
            for (int b = 0; b < MW; b++) begin
                if (bus.data_in_rd[AW+DW+b])
                    mem[wr_addr[IW-1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
`else
            mem[wr_addr[IW-1:0]] <= wr_data;
`endif
        end
        if (rd_gnt && !rd_oor)
            rd_raw <= mem[rd_addr[IW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run           <= 1'b0;
            last          <= 1'b0;
            rd_pipe_valid <= 1'b0;
            rd_pipe_oor   <= 1'b0;
            skid_wp       <= 2'd0;
            skid_rp       <= 2'd0;
            skid_cnt      <= 2'd0;
            addr_err_q    <= 1'b0;
            for (int i = 0; i < 3; i++)
                skid[i] <= '0;
        end else begin
            run           <= 1'b1;
            rd_pipe_valid <= rd_gnt;
            if (rd_gnt)
                rd_pipe_oor <= rd_oor;
            if (rd_gnt || wr_gnt)
                last <= rd_gnt;
            if (push) begin
                skid[skid_wp] <= rd_pipe_oor ? '0 : rd_raw;
                skid_wp       <= ptr_next(skid_wp);
            end
            if (pop)
                skid_rp <= ptr_next(skid_rp);
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
            if ((rd_gnt && rd_oor) || (wr_gnt && wr_oor))
                addr_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_ram.sv
module tb_fifo_ram;
    localparam int DW = 16;
    localparam int AW = 10;
`ifdef FIFO_RAM_WMASK_EN
    localparam int MW = DW / 8;
    localparam int WW = AW + DW + MW;
`else
    localparam int WW = AW + DW;
`endif
    localparam int QN = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_ram_if #(.DW(DW), .AW(AW)) bus0 ();
    fifo_ram_if #(.DW(DW), .AW(AW)) bus1 ();

    fifo_ram #(.DW(DW), .AW(AW), .DEPTH(1000), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master));
    fifo_ram #(.DW(DW), .AW(AW), .DEPTH(1024), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // Environment FIFOs, expected-read queue and shadow memory per DUT.
    logic [WW-1:0] wfifo [2][QN];
    logic [AW-1:0] afifo [2][QN];
    logic [DW-1:0] expq  [2][QN];
    logic [DW-1:0] mmem  [2][1024];
    int w_head[2], w_tail[2], a_head[2], a_tail[2], e_head[2], e_tail[2];
    logic full[2];
    int gnt_tot[2], push_tot[2];
    logic gnt_prev[2], last_m[2], err_m[2];
    int last_rgnt_cyc[2], last_push_cyc[2];
    logic [DW-1:0] last_push_data[2];
    int glog[2][64];
    int glog_n[2];
    int stall_cnt[2];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [WW-1:0] mk_word(input logic [AW-1:0] a, input logic [DW-1:0] dt);
`ifdef FIFO_RAM_WMASK_EN
        return {{MW{1'b1}}, a, dt};
`else
        return {a, dt};
`endif
    endfunction

    task automatic push_w(input int d, input logic [AW-1:0] a, input logic [DW-1:0] dt);
        wfifo[d][w_tail[d] % QN] = mk_word(a, dt);
        w_tail[d]++;
    endtask

    task automatic push_a(input int d, input logic [AW-1:0] a);
        afifo[d][a_tail[d] % QN] = a;
        a_tail[d]++;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            w_head[d] = 0; w_tail[d] = 0; a_head[d] = 0; a_tail[d] = 0;
            e_head[d] = 0; e_tail[d] = 0;
            gnt_tot[d] = 0; push_tot[d] = 0;
            gnt_prev[d] = 1'b0; last_m[d] = 1'b0; err_m[d] = 1'b0;
            full[d] = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        bus0.data_in_empty = (w_head[0] == w_tail[0]);
        bus0.data_in_rd    = wfifo[0][w_head[0] % QN];
        bus0.addr_in_empty = (a_head[0] == a_tail[0]);
        bus0.addr_in_rd    = afifo[0][a_head[0] % QN];
        bus0.data_out_full = full[0];
        bus1.data_in_empty = (w_head[1] == w_tail[1]);
        bus1.data_in_rd    = wfifo[1][w_head[1] % QN];
        bus1.addr_in_empty = (a_head[1] == a_tail[1]);
        bus1.addr_in_rd    = afifo[1][a_head[1] % QN];
        bus1.data_out_full = full[1];
    endtask

    // Reference: grant rules, N+2 read latency, credit of 3 outstanding reads,
    // in-order read data from a shadow memory updated in grant order.
    task automatic process_cycle(input int d, input logic wr, input logic ar, input logic we,
                                 input logic [DW-1:0] wd, input logic er);
        int outst, in_skid, dep;
        bit a_emp, w_emp, rd_req, wr_req, exp_r, exp_w, exp_we;
        logic [WW-1:0] w;
        logic [AW-1:0] ad;
        dep     = (d == 0) ? 1000 : 1024;
        a_emp   = (a_head[d] == a_tail[d]);
        w_emp   = (w_head[d] == w_tail[d]);
        outst   = gnt_tot[d] - push_tot[d];
        in_skid = outst - (gnt_prev[d] ? 1 : 0);
        rd_req  = !a_emp && outst < 3;
        wr_req  = !w_emp;
        exp_r   = rd_req && (d == 0 || !wr_req || !last_m[d]);
        exp_w   = wr_req && !exp_r;
        exp_we  = in_skid > 0 && !full[d];

        n_chk++;
        if (ar !== exp_r || wr !== exp_w) begin
            n_fail++;
            $display("FAIL grant dut%0d cyc %0d: got rd=%0b wr=%0b, expected rd=%0b wr=%0b",
                     d, cyc, ar, wr, exp_r, exp_w);
        end
        n_chk++;
        if (we !== exp_we) begin
            n_fail++;
            $display("FAIL push_strobe dut%0d cyc %0d: got %0b, expected %0b", d, cyc, we, exp_we);
        end
        n_chk++;
        if (er !== err_m[d]) begin
            n_fail++;
            $display("FAIL addr_err dut%0d cyc %0d: got %0b, expected %0b", d, cyc, er, err_m[d]);
        end
        if (!a_emp && outst == 3 && !ar) stall_cnt[d]++;

        if (we) begin
            if (e_head[d] != e_tail[d]) begin
                n_chk++;
                if (wd !== expq[d][e_head[d] % QN]) begin
                    n_fail++;
                    $display("FAIL read_data dut%0d cyc %0d: got %h, expected %h",
                             d, cyc, wd, expq[d][e_head[d] % QN]);
                end
                e_head[d]++;
            end
            push_tot[d]++;
            last_push_cyc[d]  = cyc;
            last_push_data[d] = wd;
        end
        if (wr && !w_emp) begin
            w = wfifo[d][w_head[d] % QN];
            w_head[d]++;
            ad = w[AW+DW-1:DW];
            if (int'(ad) >= dep) err_m[d] = 1'b1;
            else begin
`ifdef FIFO_RAM_WMASK_EN
                for (int b = 0; b < MW; b++)
                    if (w[AW+DW+b]) mmem[d][ad][b*8 +: 8] = w[b*8 +: 8];
`else
                mmem[d][ad] = w[DW-1:0];
`endif
            end
        end
        gnt_prev[d] = ar && !a_emp;
        if (ar && !a_emp) begin
            ad = afifo[d][a_head[d] % QN];
            a_head[d]++;
            if (int'(ad) >= dep) begin
                err_m[d] = 1'b1;
                expq[d][e_tail[d] % QN] = '0;
            end else begin
                expq[d][e_tail[d] % QN] = mmem[d][ad];
            end
            e_tail[d]++;
            gnt_tot[d]++;
            last_rgnt_cyc[d] = cyc;
        end
        if (ar || wr) last_m[d] = ar;
        if (glog_n[d] < 64) begin
            glog[d][glog_n[d]] = ar ? 1 : (wr ? 2 : 0);
            glog_n[d]++;
        end
    endtask

    task automatic step();
        logic wr0, ar0, we0, er0, wr1, ar1, we1, er1;
        logic [DW-1:0] wd0, wd1;
        @(negedge clk);
        cyc++;
        wr0 = bus0.data_in_ren; ar0 = bus0.addr_in_ren; we0 = bus0.data_out_wen;
        wd0 = bus0.data_out_wd; er0 = bus0.addr_err;
        wr1 = bus1.data_in_ren; ar1 = bus1.addr_in_ren; we1 = bus1.data_out_wen;
        wd1 = bus1.data_out_wd; er1 = bus1.addr_err;
        process_cycle(0, wr0, ar0, we0, wd0, er0);
        process_cycle(1, wr1, ar1, we1, wd1, er1);
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    function automatic bit idle();
        for (int d = 0; d < 2; d++)
            if (w_head[d] != w_tail[d] || a_head[d] != a_tail[d] ||
                e_head[d] != e_tail[d]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        full[0] = 1'b0; full[1] = 1'b0;
        drive_inputs();
        for (int k = 0; k < 400; k++) begin
            if (idle()) break;
            step();
        end
        n_chk++;
        if (!idle()) begin
            n_fail++;
            $display("FAIL drain: traffic still pending after 400 cycles, expected idle");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_chk++;
        if ({bus0.data_out_wen, bus0.data_in_ren, bus0.addr_in_ren, bus0.addr_err,
             bus1.data_out_wen, bus1.data_in_ren, bus1.addr_in_ren, bus1.addr_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_strobes: got dut0 wen/wren/aren/err=%b%b%b%b dut1=%b%b%b%b, expected all 0",
                     tag, bus0.data_out_wen, bus0.data_in_ren, bus0.addr_in_ren, bus0.addr_err,
                     bus1.data_out_wen, bus1.data_in_ren, bus1.addr_in_ren, bus1.addr_err);
        end
        n_chk++;
        if (bus0.data_out_wd !== '0 || bus1.data_out_wd !== '0) begin
            n_fail++;
            $display("FAIL %s_wd: got %h/%h, expected 0000/0000", tag, bus0.data_out_wd, bus1.data_out_wd);
        end
    endtask

    task automatic wait_pushes(input int d, input int target, input string tag);
        for (int k = 0; k < 60; k++) begin
            if (push_tot[d] >= target) break;
            step();
        end
        n_chk++;
        if (push_tot[d] < target) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pushes, expected %0d", tag, push_tot[d], target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reset_model();
        drive_inputs();
        #2;
        bus0.addr_in_empty = 1'b0; bus0.data_in_empty = 1'b0;
        bus1.addr_in_empty = 1'b0; bus1.data_in_empty = 1'b0;
        #1;
        check_reset_outputs("reset");
        drive_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        check_reset_outputs("post_reset");
    endtask

    task automatic test_basic();
        int p0;
        push_w(0, 10'h005, 16'hBEEF);
        drive_inputs();
        repeat (3) step();
        p0 = push_tot[0];
        push_a(0, 10'h005);
        drive_inputs();
        wait_pushes(0, p0 + 1, "basic");
        n_chk++;
        if (last_push_cyc[0] - last_rgnt_cyc[0] != 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, expected 2", last_push_cyc[0] - last_rgnt_cyc[0]);
        end
        n_chk++;
        if (last_push_data[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL basic_data: got %h, expected beef", last_push_data[0]);
        end
        repeat (4) step();
        n_chk++;
        if (push_tot[0] != p0 + 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pushes, expected %0d", push_tot[0] - p0, 1);
        end
    endtask

    task automatic test_arb();
        int nr, nw;
        for (int i = 0; i < 4; i++) begin
            push_w(0, AW'(20 + i), DW'($urandom));
            push_w(1, AW'(20 + i), DW'($urandom));
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 2; d++) begin
                push_w(d, AW'(30 + i), DW'($urandom));
                push_a(d, AW'(20 + i));
            end
        end
        drive_inputs();
        glog_n[0] = 0; glog_n[1] = 0;
        repeat (4) step();
        nr = 0; nw = 0;
        for (int i = 0; i < 4; i++) begin
            if (glog[0][i] == 1) nr++;
            if (glog[0][i] == 2) nw++;
        end
        n_chk++;
        if (nr != 4 || nw != 0) begin
            n_fail++;
            $display("FAIL arb_fixed: got %0d reads %0d writes, expected 4 reads 0 writes", nr, nw);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (glog[1][i] != ((i % 2 == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL arb_rr_%0d: got grant code %0d, expected %0d", i, glog[1][i], (i % 2 == 0) ? 1 : 2);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int p0, s0;
        for (int i = 0; i < 10; i++) push_w(0, AW'(40 + i), DW'($urandom));
        drain();
        p0 = push_tot[0];
        s0 = stall_cnt[0];
        for (int i = 0; i < 10; i++) push_a(0, AW'(40 + i));
        for (int i = 1; i <= 40; i++) begin
            full[0] = (i >= 3 && i <= 8);
            drive_inputs();
            step();
        end
        n_chk++;
        if (push_tot[0] - p0 != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pushes, expected 10", push_tot[0] - p0);
        end
        n_chk++;
        if (stall_cnt[0] == s0) begin
            n_fail++;
            $display("FAIL bp_stall: got 0 stalled cycles, expected at least 1");
        end
        drain();
    endtask

    task automatic test_oor();
        int p0;
        push_w(0, 10'd1000, 16'h1234);
        drive_inputs();
        repeat (3) step();
        n_chk++;
        if (bus0.addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write_err: got %0b, expected 1", bus0.addr_err);
        end
        p0 = push_tot[0];
        push_a(0, 10'd1000);
        drive_inputs();
        wait_pushes(0, p0 + 1, "oor");
        n_chk++;
        if (last_push_data[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor_read_data: got %h, expected 0000", last_push_data[0]);
        end
        repeat (5) step();
        n_chk++;
        if (bus0.addr_err !== 1'b1 || bus1.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_sticky: got dut0=%0b dut1=%0b, expected 1/0", bus0.addr_err, bus1.addr_err);
        end
    endtask

`ifdef FIFO_RAM_WMASK_EN
    task automatic test_mask();
        int p0;
        wfifo[1][w_tail[1] % QN] = {2'b11, 10'd50, 16'h1234}; w_tail[1]++;
        wfifo[1][w_tail[1] % QN] = {2'b10, 10'd50, 16'hABCD}; w_tail[1]++;
        drain();
        p0 = push_tot[1];
        push_a(1, 10'd50);
        drive_inputs();
        wait_pushes(1, p0 + 1, "mask");
        n_chk++;
        if (last_push_data[1] !== 16'hAB34) begin
            n_fail++;
            $display("FAIL mask_merge: got %h, expected ab34", last_push_data[1]);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 64; i++)
            for (int d = 0; d < 2; d++) push_w(d, AW'(i), DW'($urandom));
        drain();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (w_tail[d] - w_head[d] < QN - 4 && $urandom_range(0, 99) < 40)
                    push_w(d, AW'($urandom_range(0, 63)), DW'($urandom));
                if (a_tail[d] - a_head[d] < QN - 4 && $urandom_range(0, 99) < 50) begin
                    if (d == 0 && $urandom_range(0, 19) == 0)
                        push_a(0, AW'($urandom_range(1000, 1023)));
                    else
                        push_a(d, AW'($urandom_range(0, 63)));
                end
                full[d] = ($urandom_range(0, 99) < 30);
            end
            drive_inputs();
            step();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        full[0] = 1'b1;
        push_a(0, 10'h005);
        push_a(0, 10'h005);
        drive_inputs();
        for (int k = 0; k < 20; k++) begin
            if (a_head[0] == a_tail[0]) break;
            step();
        end
        n_chk++;
        if (a_head[0] != a_tail[0]) begin
            n_fail++;
            $display("FAIL midflight_grants: got %0d pending reads, expected 0", a_tail[0] - a_head[0]);
        end
        rst_n = 1'b0;
        reset_model();
        drive_inputs();
        #1;
        check_reset_outputs("midflight_reset");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        check_reset_outputs("midflight_release");
        n_chk++;
        if (push_tot[0] != 0 || push_tot[1] != 0) begin
            n_fail++;
            $display("FAIL midflight_pushes: got %0d/%0d, expected 0/0", push_tot[0], push_tot[1]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            glog_n[d] = 0; stall_cnt[d] = 0;
            last_rgnt_cyc[d] = 0; last_push_cyc[d] = 0; last_push_data[d] = '0;
        end
        test_reset();
        test_basic();
        test_arb();
        test_backpressure();
        test_oor();
`ifdef FIFO_RAM_WMASK_EN
        test_mask();
`endif
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_ram.md
# fifo_ram

Parametrised single-port frame RAM between FIFO-style command/data streams. Pops packed address+data write words and read addresses from upstream show-ahead FIFOs, and pushes read data into a downstream FIFO. It adds the following:
- configurable width, depth and arbitration;
- a pipelined read path with a skid buffer, so a late `data_out_full` never loses data;
- out-of-range address detection.

## Interface
- `DW`, 16: data word width.
- `AW`, 14: address width.
- `DEPTH`, 16384: number of words, `DEPTH` ≤ 2^AW.
- `ARB_MODE`, 0: 0 = fixed read priority; 1 = round-robin between read and write.

Ports, clock and reset first:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in_ren`  out  1: pop the write FIFO; combinational, same cycle as consumption.
- `data_in_rd`  in  WW: write word; `[AW+DW-1:DW]` = address, `[DW-1:0]` = data. WW = AW+DW, or AW+DW+DW/8 with the mask feature.
- `data_in_empty`  in  1: write FIFO empty.
- `addr_in_ren`  out  1: pop the read-address FIFO; combinational.
- `addr_in_rd`  in  AW: read address.
- `addr_in_empty`  in  1: read-address FIFO empty.
- `data_out_wen`  out  1: push the read-data FIFO.
- `data_out_wd`  out  DW: read data.
- `data_out_full`  in  1: read-data FIFO full.
- `addr_err`  out  1: sticky; set on any out-of-range access.

## Operation
- One memory access per cycle, single port. A write and a read are never granted in the same cycle.
- **Read request:** `~addr_in_empty` and credit available. Credit means `skid_cnt + rd_pipe_valid < 3`.
- **Write request:** `~data_in_empty`.
- **Arbitration, `ARB_MODE`=0:** read wins whenever both requests are present.
- **Arbitration, `ARB_MODE`=1:**
  - A 1-bit `last` register selects the grant when both requests are present: the side not granted last time wins.
  - `last` updates on every grant.
  - With only one request present, that request is granted.
- **Read grant:**
  - `addr_in_ren`=1 and the memory is read at `addr_in_rd`.
  - The registered memory output is valid the next cycle (`rd_pipe_valid`) and is written into the skid at the end of that cycle.
- **Skid:**
  - 3-entry circular buffer with 2-bit read/write pointers wrapping 2→0, and a 0..3 counter.
  - `data_out_wen` = `skid_cnt != 0 && ~data_out_full`.
  - `data_out_wd` = head entry.
  - Push and pop in the same cycle leave the count unchanged.
- **Write grant:** `data_in_ren`=1 and `mem[addr] <= data` at the end of the cycle.
- **Out of range (addr ≥ `DEPTH`):**
  - A write is popped and dropped.
  - A read is popped and returns all zeros.
  - Both set `addr_err` until reset.
- Ordering between the read and write streams is not guaranteed. Ordering within each stream is preserved: reads return in request order.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- **Reset values:**
  - `data_in_ren`=0, `addr_in_ren`=0, `data_out_wen`=0 (combinational, forced by reset state).
  - `data_out_wd`=0, `addr_err`=0.
  - Skid empty, `rd_pipe_valid`=0, `last`=0 (meaning write last, so a read wins the first contention).
- **Read latency:**
  - Grant in cycle N.
  - Earliest `data_out_wen` in cycle N+2.
  - Sustained throughput is 1 read per cycle while `data_out_full`=0.
- **`data_out_full` held high:**
  - At most 3 words are accepted beyond the last push: skid fills to 3, then reads stall.
  - No data is lost or duplicated.
- **`data_out_full` deasserts:** a push occurs the same cycle.
- **Write:** data is visible to a read granted in cycle N+1 or later.
- **Reset asserted mid-operation:**
  - In-flight reads and skid contents are discarded immediately.
  - Entries already popped are lost.
  - After `rst_n` rises, there is no output activity before the first new grant.

## Configuration
- `FIFO_RAM_WMASK_EN` defined:
  - WW = AW+DW+DW/8; `data_in_rd[WW-1:AW+DW]` is a byte-enable mask.
  - Only bytes with mask=1 are written; mask=0 still pops the word.
  - `DW` must be a multiple of 8.
- Not defined:
  - WW = AW+DW.
  - Every write updates the full word.

## Test plan
1. Reset, then write {addr 0x0005, data 0xBEEF}, then read 0x0005 → one `data_out_wen` 2 cycles after the read grant, `data_out_wd`=0xBEEF.
2. `ARB_MODE`=0, both FIFOs non-empty for 4 cycles → 4 consecutive `addr_in_ren` and no `data_in_ren`. With `ARB_MODE`=1 → grants alternate R,W,R,W.
3. 10 back-to-back reads with `data_out_full` asserted for cycles 3–8 → exactly 10 pushes, in order. `addr_in_ren` stalls while `skid_cnt + rd_pipe_valid` = 3.
4. `DEPTH`=1000: write to 1000, then read 1000 → write dropped, read returns 0x0000, `addr_err`=1 and stays 1.
5. `FIFO_RAM_WMASK_EN`: write 0x1234, then 0xABCD with mask 2'b10, then read → 0xAB34.
6. Assert `rst_n`=0 with 2 reads in flight → no `data_out_wen` after release, and all outputs at reset values.
